mult_accumulator: RTL and testbench
===================================

# mult_accumulator

Sequential accumulation stage directly downstream of the combinational `multiplier`. It consumes one `Product` per accepted handshake and sums `N_TERMS` consecutive products into a wide accumulator. It then presents the dot-product result on a valid/ready output port and holds it until the consumer accepts it. One result is produced per `N_TERMS` accepted products.

## Interface
- `WIDTH`, 4: operand width of the upstream multiplier; product input is `2*WIDTH` bits.
- `ACC_WIDTH`, 16: accumulator/result width; must be ≥ `2*WIDTH`.
- `N_TERMS`, 4: products summed per result; must be ≥ 1.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort; discards the partial sum and any pending result.
- `in_valid` input 1: `product` is valid this cycle.
- `in_ready` output 1: block can accept a product this cycle.
- `product` input `2*WIDTH`: unsigned product from `multiplier.Product`.
- `out_valid` output 1: `result` holds a completed sum.
- `out_ready` input 1: consumer accepts `result` this cycle.
- `result` output `ACC_WIDTH`: completed unsigned sum.
- `overflow` output 1: the current result exceeded `2^ACC_WIDTH-1` at some term; valid with `out_valid`.

## Operation
- States: ACCUM and HOLD. Reset state is ACCUM.
- Internal term counter: `$clog2(N_TERMS)` bits, minimum 1 bit. Reset value is 0.
- ACCUM behaviour:
  - `in_ready`=1, `out_valid`=0.
  - Accept occurs when `in_valid && in_ready`.
  - On accept: `acc <= acc + zero_extend(product)` and `count <= count+1`.
  - An accept with `count==N_TERMS-1` moves the block to HOLD and resets `count` to 0.
- HOLD behaviour:
  - `in_ready`=0, `out_valid`=1. `result`=`acc`.
  - `result` and `overflow` are stable until `out_ready`=1.
  - `out_ready`=1: `acc`←0, `overflow`←0, go to ACCUM.
- Arithmetic: unsigned. Addition is computed at `ACC_WIDTH+1` bits; the carry-out bit is the overflow condition. Overflow handling is defined under Configuration.
- `overflow` is sticky within one result and cleared on result handoff, `clear`, or reset.
- `clear`=1 has priority over every other event. Next state: ACCUM, `acc`=0, `count`=0, `overflow`=0. A product offered in the same cycle is not accepted; `in_ready` still reads 1 if in ACCUM.
- `N_TERMS`=1: every accept goes straight to HOLD.
- Input while in HOLD: no accept, because `in_ready`=0. The upstream must hold `product`/`in_valid`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `overflow`=0, `acc`=0, `count`=0.
- Async assertion of `rst_n` takes effect immediately, including mid-accumulation or in HOLD. The partial sum is lost.
- `in_ready` and `out_valid` are decoded from the state register only; there is no combinational path from `in_valid`/`out_ready`.
- Throughput: one product accepted per cycle in ACCUM.
- Latency: `out_valid` rises on the cycle after the Nth accept, and `result` includes the Nth product.
- Earliest next accept is the cycle after the output handshake. No bubble-free overlap: at least 1 idle input cycle per result.
- `product` is sampled only on accept cycles; its value at other times is don't-care.

## Configuration
- `MULT_ACC_SAT_EN` defined: on carry-out, `acc` clamps to `2^ACC_WIDTH-1` and `overflow`←1. Subsequent adds in the same result stay clamped.
- `MULT_ACC_SAT_EN` undefined: `acc` wraps modulo `2^ACC_WIDTH` and `overflow`←1 on carry-out. Further adds continue from the wrapped value.
- Ports and timing are identical in both builds.

## Test plan
- WIDTH=4, ACC_WIDTH=16, N_TERMS=4:
  - Stimulus: products 6, 15, 225, 0 on consecutive cycles, `out_ready`=1.
  - Required: `out_valid` one cycle after the 4th accept, `result`=246, `overflow`=0, `in_ready` back to 1 the next cycle.
- Backpressure:
  - Stimulus: complete a result, then hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `product`=9.
  - Required: `result` stable, `in_ready`=0 throughout, no product lost. After the handshake, 9 is the first term of the next sum.
- Overflow, ACC_WIDTH=8, N_TERMS=2, products 225, 225:
  - With `MULT_ACC_SAT_EN`: `result`=255, `overflow`=1.
  - Without: `result`=194, `overflow`=1.
  - `overflow` reads 0 after the handoff.
- Gapped input:
  - Stimulus: `in_valid` toggled 1,0,0,1,1,0,1 with products 1,2,3,4.
  - Required: `result`=10, produced one cycle after the 4th accept.
- Reset mid-operation:
  - Stimulus: 2 terms accepted, drop `rst_n` between clock edges.
  - Required: outputs go to reset values immediately. The next 4 products 1,1,1,1 give `result`=4.
- `clear`:
  - Stimulus A: assert `clear` in HOLD. Required: `out_valid`→0 next cycle.
  - Stimulus B: assert `clear` together with `in_valid` after 3 terms. Required: that product is dropped and a fresh 4-term sum follows.

Source files
------------

// File: rtl/mult_accumulator.sv
// Accumulates N_TERMS unsigned products into one result and returns it over a valid/ready handshake.
// Optional build macro: MULT_ACC_SAT_EN (saturating accumulate instead of wrapping).
module mult_accumulator #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned N_TERMS   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*WIDTH-1:0]     product,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_WIDTH-1:0]   result,
   output logic                   overflow
);

   localparam int unsigned       CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_TERMS - 1);

   typedef enum logic {
      ACCUM,
      HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic [ACC_WIDTH:0]    sum;

   // One extra bit so the carry-out is the overflow flag.
   assign sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(product);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
`ifdef MULT_ACC_SAT_EN
                  acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
                  acc_d = sum[ACC_WIDTH-1:0];
`endif
                  ovf_d = ovf_q | sum[ACC_WIDTH];
                  if (cnt_q == LAST) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign result    = acc_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator: 16-bit/4-term instance A and 8-bit/2-term instance B.
module tb_mult_accumulator;

   localparam int AW_A = 16;
   localparam int N_A  = 4;
   localparam int AW_B = 8;
   localparam int N_B  = 2;
`ifdef MULT_ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;

   logic        clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a;
   logic [7:0]  product_a;
   logic [15:0] result_a;
   logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b;
   logic [7:0]  product_b;
   logic [7:0]  result_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: running sum, term count, hold flag, sticky overflow.
   longint a_acc, b_acc;
   int     a_terms, b_terms;
   bit     a_hold, b_hold, a_ovf, b_ovf;

   mult_accumulator #(.WIDTH(4), .ACC_WIDTH(AW_A), .N_TERMS(N_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .product(product_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .result(result_a), .overflow(overflow_a));

   mult_accumulator #(.WIDTH(4), .ACC_WIDTH(AW_B), .N_TERMS(N_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .product(product_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .result(result_b), .overflow(overflow_b));

   always #5 clk = ~clk;

   function automatic void add_term(inout longint acc, inout bit ov, input int p, input int aw);
      longint maxv;
      maxv = (longint'(1) << aw) - 1;
      acc  = acc + p;
      if (acc > maxv) begin
         ov  = 1'b1;
         acc = SAT ? maxv : acc - (maxv + 1);
      end
   endfunction

   task automatic model_reset();
      a_acc = 0; a_terms = 0; a_hold = 0; a_ovf = 0;
      b_acc = 0; b_terms = 0; b_hold = 0; b_ovf = 0;
   endtask

   task automatic step_a(input bit v, input int p, input bit ordy, input bit clr);
      in_valid_a = v; product_a = 8'(p); out_ready_a = ordy; clear_a = clr;
      if (clr) begin
         a_acc = 0; a_terms = 0; a_hold = 0; a_ovf = 0;
      end else if (a_hold) begin
         if (ordy) begin a_hold = 0; a_acc = 0; a_ovf = 0; end
      end else if (v) begin
         add_term(a_acc, a_ovf, p & 8'hFF, AW_A);
         a_terms++;
         if (a_terms == N_A) begin a_terms = 0; a_hold = 1; end
      end
      @(negedge clk);
   endtask

   task automatic step_b(input bit v, input int p, input bit ordy, input bit clr);
      in_valid_b = v; product_b = 8'(p); out_ready_b = ordy; clear_b = clr;
      if (clr) begin
         b_acc = 0; b_terms = 0; b_hold = 0; b_ovf = 0;
      end else if (b_hold) begin
         if (ordy) begin b_hold = 0; b_acc = 0; b_ovf = 0; end
      end else if (v) begin
         add_term(b_acc, b_ovf, p & 8'hFF, AW_B);
         b_terms++;
         if (b_terms == N_B) begin b_terms = 0; b_hold = 1; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_a); end
      n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_a); end
      n_checks++; if (result_a !== 16'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result_a); end
      n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow_a); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_release: got rdy=%0b vld=%0b expected rdy=1 vld=0", in_ready_a, out_valid_a); end
   endtask

   task automatic test_basic();
      int prods[4] = '{6, 15, 225, 0};
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d]: got %0b expected 0", i, out_valid_a); end
         step_a(1'b1, prods[i], 1'b1, 1'b0);
      end
      n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", out_valid_a); end
      n_checks++; if (result_a !== 16'd246) begin n_fail++; $display("FAIL basic_result: got %0d expected 246", result_a); end
      n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0b expected 0", overflow_a); end
      n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready: got %0b expected 0", in_ready_a); end
      step_a(1'b0, 0, 1'b1, 1'b0);
      n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_after_handoff: got rdy=%0b vld=%0b expected rdy=1 vld=0", in_ready_a, out_valid_a); end
   endtask

   task automatic test_backpressure();
      int r[3];
      longint held;
      for (int i = 0; i < 4; i++) step_a(1'b1, $urandom_range(0, 225), 1'b0, 1'b0);
      held = a_acc;
      n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'(held)) begin n_fail++; $display("FAIL bp_first_result: got vld=%0b res=%0d expected vld=1 res=%0d", out_valid_a, result_a, held); end
      for (int i = 0; i < 5; i++) begin
         step_a(1'b1, 9, 1'b0, 1'b0);
         n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", i, in_ready_a); end
         n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'(held)) begin n_fail++; $display("FAIL bp_stable[%0d]: got vld=%0b res=%0d expected vld=1 res=%0d", i, out_valid_a, result_a, held); end
      end
      step_a(1'b1, 9, 1'b1, 1'b0);
      n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_handoff: got rdy=%0b vld=%0b expected rdy=1 vld=0", in_ready_a, out_valid_a); end
      step_a(1'b1, 9, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         r[i] = $urandom_range(0, 225);
         step_a(1'b1, r[i], 1'b0, 1'b0);
      end
      n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'(9 + r[0] + r[1] + r[2])) begin n_fail++; $display("FAIL bp_next_sum: got vld=%0b res=%0d expected vld=1 res=%0d", out_valid_a, result_a, 9 + r[0] + r[1] + r[2]); end
      step_a(1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_gapped();
      bit vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int k = 1;
      for (int i = 0; i < 7; i++) begin
         n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid[%0d]: got %0b expected 0", i, out_valid_a); end
         if (vpat[i]) begin step_a(1'b1, k, 1'b0, 1'b0); k++; end
         else step_a(1'b0, $urandom_range(0, 255), 1'b0, 1'b0);
      end
      n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'd10) begin n_fail++; $display("FAIL gap_result: got vld=%0b res=%0d expected vld=1 res=10", out_valid_a, result_a); end
      step_a(1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_clear();
      int f[4];
      for (int i = 0; i < 4; i++) step_a(1'b1, $urandom_range(0, 225), 1'b0, 1'b0);
      n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL clr_pre_hold: got %0b expected 1", out_valid_a); end
      step_a(1'b0, 0, 1'b0, 1'b1);
      n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL clr_in_hold: got vld=%0b rdy=%0b expected vld=0 rdy=1", out_valid_a, in_ready_a); end
      for (int i = 0; i < 3; i++) step_a(1'b1, $urandom_range(1, 225), 1'b0, 1'b0);
      step_a(1'b1, 77, 1'b0, 1'b1);
      n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL clr_with_input: got vld=%0b rdy=%0b expected vld=0 rdy=1", out_valid_a, in_ready_a); end
      for (int i = 0; i < 4; i++) begin
         f[i] = $urandom_range(0, 225);
         if (i == 3) begin
            n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL clr_fresh_early: got %0b expected 0", out_valid_a); end
         end
         step_a(1'b1, f[i], 1'b0, 1'b0);
      end
      n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'(f[0] + f[1] + f[2] + f[3])) begin n_fail++; $display("FAIL clr_fresh_sum: got vld=%0b res=%0d expected vld=1 res=%0d", out_valid_a, result_a, f[0] + f[1] + f[2] + f[3]); end
      step_a(1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      step_a(1'b1, 100, 1'b0, 1'b0);
      step_a(1'b1, 50, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got rdy=%0b vld=%0b expected rdy=1 vld=0", in_ready_a, out_valid_a); end
      n_checks++; if (result_a !== 16'd0 || overflow_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got res=%0d ovf=%0b expected res=0 ovf=0", result_a, overflow_a); end
      model_reset();
      in_valid_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step_a(1'b1, 1, 1'b0, 1'b0);
      n_checks++; if (out_valid_a !== 1'b1 || result_a !== 16'd4) begin n_fail++; $display("FAIL rstmid_next_sum: got vld=%0b res=%0d expected vld=1 res=4", out_valid_a, result_a); end
      step_a(1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_random_a();
      for (int i = 0; i < 400; i++) begin
         step_a(($urandom % 4) != 0, $urandom_range(0, 255), $urandom % 2, ($urandom % 25) == 0);
         n_checks++; if (in_ready_a !== !a_hold || out_valid_a !== a_hold) begin n_fail++; $display("FAIL rand_a_flags[%0d]: got rdy=%0b vld=%0b expected rdy=%0b vld=%0b", i, in_ready_a, out_valid_a, !a_hold, a_hold); end
         if (a_hold) begin
            n_checks++; if (result_a !== 16'(a_acc) || overflow_a !== a_ovf) begin n_fail++; $display("FAIL rand_a_result[%0d]: got res=%0d ovf=%0b expected res=%0d ovf=%0b", i, result_a, overflow_a, a_acc, a_ovf); end
         end
      end
      step_a(1'b0, 0, 1'b1, 1'b1);
   endtask

   task automatic test_overflow();
      step_b(1'b1, 225, 1'b0, 1'b0);
      step_b(1'b1, 225, 1'b0, 1'b0);
      n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %0b expected 1", out_valid_b); end
      n_checks++; if (result_b !== (SAT ? 8'd255 : 8'd194)) begin n_fail++; $display("FAIL ovf_result: got %0d expected %0d", result_b, SAT ? 255 : 194); end
      n_checks++; if (overflow_b !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow_b); end
      step_b(1'b0, 0, 1'b1, 1'b0);
      n_checks++; if (overflow_b !== 1'b0 || out_valid_b !== 1'b0) begin n_fail++; $display("FAIL ovf_after_handoff: got ovf=%0b vld=%0b expected 0 0", overflow_b, out_valid_b); end
      for (int i = 0; i < 300; i++) begin
         step_b(($urandom % 3) != 0, $urandom_range(0, 255), $urandom % 2, ($urandom % 30) == 0);
         n_checks++; if (in_ready_b !== !b_hold || out_valid_b !== b_hold) begin n_fail++; $display("FAIL rand_b_flags[%0d]: got rdy=%0b vld=%0b expected rdy=%0b vld=%0b", i, in_ready_b, out_valid_b, !b_hold, b_hold); end
         if (b_hold) begin
            n_checks++; if (result_b !== 8'(b_acc) || overflow_b !== b_ovf) begin n_fail++; $display("FAIL rand_b_result[%0d]: got res=%0d ovf=%0b expected res=%0d ovf=%0b", i, result_b, overflow_b, b_acc, b_ovf); end
         end
      end
      step_b(1'b0, 0, 1'b1, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      clear_a = 0; in_valid_a = 0; out_ready_a = 0; product_a = '0;
      clear_b = 0; in_valid_b = 0; out_ready_b = 0; product_b = '0;
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_clear();
      test_reset_mid();
      test_random_a();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
